// File: rtl/hard_disk_controller.sv
`default_nettype none
// ============================================================================
// Module      : hard_disk_controller
// Description : Single-command disk controller over a 1024 x 32 word store
//               addressed by {track, sector}. Supports word READ, word WRITE
//               and LOAD of a block into instruction memory, one command at
//               a time (IDLE -> READ/WRITE/LOAD -> DONE -> IDLE).
// Ports       : clock, reset          - clock, synchronous active-high reset
//               cmdValid, cmd          - command strobe (sampled in IDLE), code
//               track, sector          - word address (3 + 7 bits)
//               dataIn                 - WRITE data
//               destAddr, length       - LOAD destination base and word count
//               busy, done, error      - status; error valid while done=1
//               dataHD                 - registered READ result
//               miWriteEnable, miAddress, miData - instruction-memory writes
// Revision    : 1.0 - initial release
// ============================================================================
module hard_disk_controller (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmdValid,
    input  logic [1:0]  cmd,
    input  logic [2:0]  track,
    input  logic [6:0]  sector,
    input  logic [31:0] dataIn,
    input  logic [11:0] destAddr,
    input  logic [7:0]  length,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] dataHD,
    output logic        miWriteEnable,
    output logic [11:0] miAddress,
    output logic [31:0] miData
);

    localparam int         WORDS      = 1024;
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_READ     = 3'd1;
    localparam logic [2:0] S_WRITE    = 3'd2;
    localparam logic [2:0] S_LOAD     = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;
    localparam logic [1:0] CMD_READ   = 2'd0;
    localparam logic [1:0] CMD_WRITE  = 2'd1;
    localparam logic [1:0] CMD_LOAD   = 2'd2;
    localparam logic [8:0] TRACK_SIZE = 9'd128;

    logic [2:0]  state_q, state_d;
    logic        err_q, err_d;
    logic [2:0]  track_q;
    logic [6:0]  sector_q;
    logic [31:0] data_q;
    logic [11:0] dest_q;
    logic [7:0]  len_q;
    logic [7:0]  cnt_q;
    logic [31:0] dataHD_q;
    logic        we_q;
    logic [11:0] miaddr_q;
    logic [31:0] midata_q;
    logic [31:0] mem_q [0:WORDS-1];

    logic        load_reject;
    logic        load_exit;
    logic [9:0]  word_addr;
    logic [9:0]  load_addr;

    // 9-bit sum so that sector+length overflow past the track is visible.
    assign load_reject = (({2'b00, sector_q} + {1'b0, len_q}) > TRACK_SIZE);
    // Leave LOAD once rejected, or one cycle after the last read was issued
    // so that the final write strobe is still presented.
    assign load_exit   = load_reject || (cnt_q == len_q);
    assign word_addr   = {track_q, sector_q};
    assign load_addr   = {track_q, sector_q + cnt_q[6:0]};

    // ---------------- state register ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmdValid) begin
                    case (cmd)
                        CMD_READ:  state_d = S_READ;
                        CMD_WRITE: state_d = S_WRITE;
                        CMD_LOAD:  state_d = S_LOAD;
                        default: begin
                            state_d = S_DONE;
                            err_d   = 1'b1;
                        end
                    endcase
                end
            end
            S_READ:  state_d = S_DONE;
            S_WRITE: state_d = S_DONE;
            S_LOAD: begin
                if (load_exit) begin
                    state_d = S_DONE;
                    err_d   = load_reject;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        if (state_q != S_IDLE) busy = 1'b1;
        if (state_q == S_DONE) done = 1'b1;
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            err_q    <= 1'b0;
            track_q  <= '0;
            sector_q <= '0;
            data_q   <= '0;
            dest_q   <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            dataHD_q <= '0;
            we_q     <= 1'b0;
            miaddr_q <= '0;
            midata_q <= '0;
        end else begin
            we_q <= 1'b0;
            if ((state_q == S_IDLE) && cmdValid) begin
                track_q  <= track;
                sector_q <= sector;
                data_q   <= dataIn;
                dest_q   <= destAddr;
                len_q    <= length;
                cnt_q    <= '0;
            end
            if (state_q == S_READ) begin
                dataHD_q <= mem_q[word_addr];
            end
            // Word i is read here and strobed out on the following cycle.
            if ((state_q == S_LOAD) && !load_exit) begin
                midata_q <= mem_q[load_addr];
                miaddr_q <= dest_q + {4'b0000, cnt_q};
                we_q     <= 1'b1;
                cnt_q    <= cnt_q + 8'd1;
            end
            // Error only changes on entry to DONE and holds until the next one.
            if ((state_d == S_DONE) && (state_q != S_DONE)) begin
                err_q <= err_d;
            end
        end
    end

    // Storage is deliberately not reset; a reset only blocks a pending write.
    always_ff @(posedge clock) begin
        if (!reset && (state_q == S_WRITE)) begin
            mem_q[word_addr] <= data_q;
        end
    end

    assign error         = err_q;
    assign dataHD        = dataHD_q;
    assign miWriteEnable = we_q;
    assign miAddress     = miaddr_q;
    assign miData        = midata_q;

endmodule
`default_nettype wire

// File: tb/tb_hard_disk_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_hard_disk_controller
// Description : Directed self-checking bench for hard_disk_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hard_disk_controller;

    logic        clock = 1'b0;
    logic        reset;
    logic        cmdValid;
    logic [1:0]  cmd;
    logic [2:0]  track;
    logic [6:0]  sector;
    logic [31:0] dataIn;
    logic [11:0] destAddr;
    logic [7:0]  length;
    logic        busy, done, error;
    logic [31:0] dataHD;
    logic        miWriteEnable;
    logic [11:0] miAddress;
    logic [31:0] miData;

    hard_disk_controller dut (
        .clock(clock), .reset(reset), .cmdValid(cmdValid), .cmd(cmd),
        .track(track), .sector(sector), .dataIn(dataIn), .destAddr(destAddr),
        .length(length), .busy(busy), .done(done), .error(error),
        .dataHD(dataHD), .miWriteEnable(miWriteEnable), .miAddress(miAddress),
        .miData(miData)
    );

    always #5 clock = ~clock;

    int compared   = 0;
    int mismatched = 0;

    // observations collected by run_cmd
    int          n_strobes, done_cyc, first_cyc, last_cyc;
    logic        err_at_done, busy_c1;
    logic [31:0] hd_at_done;
    logic [11:0] s_addr[$];
    logic [31:0] s_data[$];
    int          post_strobes, post_done;
    logic        post_busy;

    // Issue one command; cycle k = k-th falling edge after the accepting edge.
    task automatic run_cmd(input logic [1:0] c, input logic [2:0] t,
                           input logic [6:0] s, input logic [31:0] d,
                           input logic [11:0] da, input logic [7:0] len,
                           input int pulse_cyc, input int rst_after);
        n_strobes = 0; done_cyc = 0; first_cyc = 0; last_cyc = 0;
        err_at_done = 1'bx; hd_at_done = 'x; busy_c1 = 1'bx;
        post_strobes = 0; post_done = 0; post_busy = 1'b0;
        s_addr.delete(); s_data.delete();
        @(negedge clock);
        cmd = c; track = t; sector = s; dataIn = d; destAddr = da; length = len;
        cmdValid = 1'b1;
        @(posedge clock);
        #1 cmdValid = 1'b0;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            @(negedge clock);
            cmdValid = 1'b0;
            if (cyc == 1) busy_c1 = busy;
            if (miWriteEnable) begin
                n_strobes++;
                s_addr.push_back(miAddress);
                s_data.push_back(miData);
                if (first_cyc == 0) first_cyc = cyc;
                last_cyc = cyc;
            end
            if (done) begin
                done_cyc    = cyc;
                err_at_done = error;
                hd_at_done  = dataHD;
                break;
            end
            if (cyc == pulse_cyc) begin
                cmd = 2'd1; track = 3'd3; sector = 7'd0; dataIn = 32'h0000_0BAD;
                cmdValid = 1'b1;
            end
            if (rst_after != 0 && n_strobes == rst_after) begin
                reset = 1'b1;
                for (int k = 0; k < 6; k++) begin
                    @(negedge clock);
                    if (miWriteEnable) post_strobes++;
                    if (done) post_done++;
                    post_busy = post_busy | busy;
                    if (k == 0) reset = 1'b0;
                end
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; cmdValid = 1'b0; cmd = '0; track = '0; sector = '0;
        dataIn = '0; destAddr = '0; length = '0;
        repeat (3) @(negedge clock);
        compared++;
        if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0 || miWriteEnable !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_status: busy/done/err/we=%b%b%b%b expected 0000",
                     busy, done, error, miWriteEnable);
        end
        compared++;
        if (dataHD !== 32'h0 || miAddress !== 12'h0) begin
            mismatched++;
            $display("FAIL reset_regs: dataHD=%h miAddress=%h expected 0/0", dataHD, miAddress);
        end
        reset = 1'b0;
    endtask

    task automatic test_write_read;
        run_cmd(2'd1, 3'd2, 7'd5, 32'hDEADBEEF, 12'h0, 8'd0, 0, 0);
        compared++;
        if (done_cyc !== 2 || err_at_done !== 1'b0 || busy_c1 !== 1'b1) begin
            mismatched++;
            $display("FAIL write_done: cyc=%0d err=%b busy1=%b expected 2/0/1",
                     done_cyc, err_at_done, busy_c1);
        end
        run_cmd(2'd0, 3'd2, 7'd5, 32'h0, 12'h0, 8'd0, 0, 0);
        compared++;
        if (done_cyc !== 2 || err_at_done !== 1'b0) begin
            mismatched++;
            $display("FAIL read_done: cyc=%0d err=%b expected 2/0", done_cyc, err_at_done);
        end
        compared++;
        if (hd_at_done !== 32'hDEADBEEF) begin
            mismatched++;
            $display("FAIL read_data: got %h expected deadbeef", hd_at_done);
        end
    endtask

    task automatic test_load_wrap;
        logic [11:0] exp_a [4] = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
        for (int i = 0; i < 4; i++)
            run_cmd(2'd1, 3'd1, 7'(i), 32'h10 + 32'(i), 12'h0, 8'd0, 0, 0);
        run_cmd(2'd2, 3'd1, 7'd0, 32'h0, 12'hFFE, 8'd4, 0, 0);
        compared++;
        if (n_strobes !== 4 || first_cyc !== 2 || last_cyc !== 5 || done_cyc !== 6 || err_at_done !== 1'b0) begin
            mismatched++;
            $display("FAIL load4_timing: n=%0d first=%0d last=%0d done=%0d err=%b expected 4/2/5/6/0",
                     n_strobes, first_cyc, last_cyc, done_cyc, err_at_done);
        end
        for (int i = 0; i < 4 && i < s_addr.size(); i++) begin
            compared++;
            if (s_addr[i] !== exp_a[i] || s_data[i] !== 32'h10 + 32'(i)) begin
                mismatched++;
                $display("FAIL load4_word%0d: addr=%h data=%h expected %h/%h",
                         i, s_addr[i], s_data[i], exp_a[i], 32'h10 + 32'(i));
            end
        end
    endtask

    task automatic test_load_bounds;
        run_cmd(2'd2, 3'd1, 7'd120, 32'h0, 12'h0, 8'd9, 0, 0);
        compared++;
        if (done_cyc == 0 || err_at_done !== 1'b1 || n_strobes !== 0) begin
            mismatched++;
            $display("FAIL load_overrun: done=%0d err=%b n=%0d expected done/1/0",
                     done_cyc, err_at_done, n_strobes);
        end
        for (int i = 120; i < 128; i++)
            run_cmd(2'd1, 3'd1, 7'(i), 32'h200 + 32'(i), 12'h0, 8'd0, 0, 0);
        run_cmd(2'd2, 3'd1, 7'd120, 32'h0, 12'h010, 8'd8, 0, 0);
        compared++;
        if (n_strobes !== 8 || first_cyc !== 2 || done_cyc !== 10 || err_at_done !== 1'b0) begin
            mismatched++;
            $display("FAIL load_edge: n=%0d first=%0d done=%0d err=%b expected 8/2/10/0",
                     n_strobes, first_cyc, done_cyc, err_at_done);
        end
        if (s_data.size() == 8) begin
            compared++;
            if (s_addr[7] !== 12'h017 || s_data[7] !== 32'h27F || s_data[0] !== 32'h278) begin
                mismatched++;
                $display("FAIL load_edge_data: a7=%h d7=%h d0=%h expected 017/27f/278",
                         s_addr[7], s_data[7], s_data[0]);
            end
        end
    endtask

    task automatic test_reject_and_empty;
        run_cmd(2'd3, 3'd0, 7'd0, 32'h0, 12'h0, 8'd0, 0, 0);
        compared++;
        if (done_cyc == 0 || err_at_done !== 1'b1 || n_strobes !== 0) begin
            mismatched++;
            $display("FAIL cmd3: done=%0d err=%b n=%0d expected done/1/0",
                     done_cyc, err_at_done, n_strobes);
        end
        @(negedge clock);
        compared++;
        if (error !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL err_hold: err=%b done=%b busy=%b expected 1/0/0", error, done, busy);
        end
        run_cmd(2'd2, 3'd4, 7'd10, 32'h0, 12'h0, 8'd0, 0, 0);
        compared++;
        if (done_cyc !== 2 || err_at_done !== 1'b0 || n_strobes !== 0) begin
            mismatched++;
            $display("FAIL load_len0: done=%0d err=%b n=%0d expected 2/0/0",
                     done_cyc, err_at_done, n_strobes);
        end
    endtask

    task automatic test_busy_and_abort;
        for (int i = 0; i < 16; i++)
            run_cmd(2'd1, 3'd3, 7'(i), 32'h300 + 32'(i), 12'h0, 8'd0, 0, 0);
        run_cmd(2'd2, 3'd3, 7'd0, 32'h0, 12'h100, 8'd16, 3, 0);
        compared++;
        if (n_strobes !== 16 || done_cyc !== 18 || err_at_done !== 1'b0) begin
            mismatched++;
            $display("FAIL load16_ignore: n=%0d done=%0d err=%b expected 16/18/0",
                     n_strobes, done_cyc, err_at_done);
        end
        run_cmd(2'd2, 3'd3, 7'd0, 32'h0, 12'h100, 8'd16, 0, 5);
        compared++;
        if (n_strobes !== 5 || post_strobes !== 0 || post_done !== 0 || post_busy !== 1'b0 || done_cyc !== 0) begin
            mismatched++;
            $display("FAIL load16_abort: n=%0d post_we=%0d post_done=%0d busy=%b done=%0d expected 5/0/0/0/0",
                     n_strobes, post_strobes, post_done, post_busy, done_cyc);
        end
        compared++;
        if (dataHD !== 32'h0 || miAddress !== 12'h0 || error !== 1'b0) begin
            mismatched++;
            $display("FAIL abort_regs: dataHD=%h miAddress=%h err=%b expected 0/0/0",
                     dataHD, miAddress, error);
        end
        run_cmd(2'd0, 3'd3, 7'd0, 32'h0, 12'h0, 8'd0, 0, 0);
        compared++;
        if (hd_at_done !== 32'h300 || done_cyc !== 2) begin
            mismatched++;
            $display("FAIL keep_s0: data=%h done=%0d expected 300/2", hd_at_done, done_cyc);
        end
        run_cmd(2'd0, 3'd3, 7'd5, 32'h0, 12'h0, 8'd0, 0, 0);
        compared++;
        if (hd_at_done !== 32'h305) begin
            mismatched++;
            $display("FAIL keep_s5: data=%h expected 305", hd_at_done);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_load_wrap();
        test_load_bounds();
        test_reject_and_empty();
        test_busy_and_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hard_disk_controller.md
HARD_DISK_CONTROLLER -- requirements
Module: hard_disk_controller

Interface
REQ-001 SHALL have ports, clock and reset first, as listed in REQ-002 to REQ-016; reset is synchronous and active-high; single clock domain (clock).
REQ-002 clock  input  1  system clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 cmdValid  input  1  command strobe, sampled only in IDLE.
REQ-005 cmd  input  2  command code: 0 READ word, 1 WRITE word, 2 LOAD block to instruction memory, 3 reserved.
REQ-006 track  input  3  disk track, 8 tracks.
REQ-007 sector  input  7  word offset within track, 128 words per track.
REQ-008 dataIn  input  32  write data for WRITE.
REQ-009 destAddr  input  12  instruction-memory base address for LOAD.
REQ-010 length  input  8  word count for LOAD.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 error  output  1  valid while done=1; high = command rejected.
REQ-014 dataHD  output  32  registered READ result; feeds the datapath dataHD input.
REQ-015 miWriteEnable  output  1  instruction-memory write strobe.
REQ-016 miAddress  output 12 and miData  output 32  instruction-memory write address and data.

Function
REQ-017 SHALL hold 1024 x 32 storage addressed by {track, sector}; reads are synchronous with one cycle latency.
REQ-018 SHALL implement states IDLE, READ, WRITE, LOAD, DONE.
REQ-019 SHALL, in IDLE with cmdValid=1, latch cmd, track, sector, dataIn, destAddr and length on that edge, then go to READ (cmd 0), WRITE (cmd 1) or LOAD (cmd 2).
REQ-020 SHALL treat cmd 3 as rejected: go to DONE with error=1.
REQ-021 SHALL ignore cmdValid while busy=1; no queueing.
REQ-022 READ: dataHD <= mem[{track,sector}] on the exiting edge, then DONE; done is therefore high in the 2nd cycle after the accepting edge.
REQ-023 WRITE: mem[{track,sector}] <= dataIn on the exiting edge, then DONE.
REQ-024 LOAD, length=0: go straight to DONE, error=0, no writes.
REQ-025 LOAD, sector+length>128 (9-bit compare): go straight to DONE, error=1, no writes; LOAD never crosses a track.
REQ-026 LOAD, valid: read index i=0..length-1 from {track,sector+i}; each word's write is issued the cycle after its read.
REQ-027 LOAD timing: miWriteEnable high for exactly length consecutive cycles, starting the 2nd cycle after acceptance; miAddress=(destAddr+i) mod 4096; miData=mem word i.
REQ-028 SHALL enter DONE the cycle after the last miWriteEnable.
REQ-029 DONE: done=1 for one cycle, then IDLE unconditionally; cmdValid during DONE is ignored.
REQ-030 error SHALL be 0 on every successful completion and SHALL hold its value until the next DONE.
REQ-031 miWriteEnable SHALL be 0 outside LOAD data cycles; miAddress and miData are don't-care while miWriteEnable=0.

Reset
REQ-032 reset=1 SHALL force, on the next edge: state IDLE; busy, done, error and miWriteEnable = 0; dataHD = 0; miAddress = 0.
REQ-033 reset mid-command SHALL abort at that edge: no further memory writes, no done pulse.
REQ-034 reset SHALL NOT clear storage contents.
REQ-035 reset SHALL have priority over cmdValid.

Verification
REQ-036 WRITE track=2 sector=5 dataIn=0xDEADBEEF, then READ same -> done with error=0; dataHD=0xDEADBEEF in READ's done cycle.
REQ-037 Preload track 1 sectors 0..3 = 0x10..0x13; LOAD track=1 sector=0 length=4 destAddr=0xFFE -> 4 consecutive strobes at addresses 0xFFE, 0xFFF, 0x000, 0x001 with data 0x10..0x13; done in the cycle after the last strobe.
REQ-038 LOAD sector=120 length=9 -> done with error=1, zero strobes; LOAD sector=120 length=8 -> 8 strobes, error=0.
REQ-039 LOAD length=0 -> done 2nd cycle after acceptance, error=0, no strobes; cmd=3 -> done with error=1.
REQ-040 cmdValid pulsed during an active LOAD length=16 -> ignored, exactly 16 strobes; reset asserted after the 5th strobe -> no further strobes, no done, busy=0; stored data unchanged, checked by READ.
